// File: rtl/digit_scan_ctrl_pkg.sv
// Shared widths and state encoding for the display scan controller.
package scan_pkg;
  localparam int SEL_W      = 3;
  localparam int NIBBLE_W   = 4;
  localparam int BANK_DEPTH = 8;

  typedef enum logic {S_IDLE, S_SCAN} state_t;
endpackage

// File: rtl/digit_scan_ctrl_if.sv
// Host write/commit port of the scan controller.
interface digit_scan_ctrl_if;
  import scan_pkg::*;

  logic                wr_valid;
  logic                wr_ready;
  logic [SEL_W-1:0]    wr_addr;
  logic [NIBBLE_W-1:0] wr_data;
  logic                commit;

  modport master (output wr_valid, wr_addr, wr_data, commit, input wr_ready);
  modport slave  (input wr_valid, wr_addr, wr_data, commit, output wr_ready);
endinterface

// File: rtl/digit_scan_ctrl_prescaler.sv
// Slot prescaler: counts 0..CLK_DIV-1, flags terminal count and whether the
// next cycle lies past the anti-ghosting blank window.
module scan_prescaler #(
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tc,
  output logic en_next
);
  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  assign tc       = (cnt == CNT_W'(CLK_DIV - 1));
  assign cnt_next = (clear || tc) ? '0 : cnt + CNT_W'(1);
  // Looking one cycle ahead lets the registered sel_en line up with the count.
  assign en_next  = (int'(cnt_next) >= BLANK_CYCLES);

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_next;
  end
endmodule

// File: rtl/digit_scan_ctrl.sv
// 8-digit multiplexed display scan driver with shadow/display banks and
// tear-free frame-boundary commit.
module digit_scan_ctrl
  import scan_pkg::*;
#(
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int NUM_DIGITS   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  digit_scan_ctrl_if.slave    host,
  output logic [SEL_W-1:0]    sel,
  output logic                sel_en,
  output logic [NIBBLE_W-1:0] digit_val,
  output logic                frame_tick
);
  state_t                                 state;
  logic [BANK_DEPTH-1:0][NIBBLE_W-1:0]    shadow;
  logic [BANK_DEPTH-1:0][NIBBLE_W-1:0]    disp;
  logic [BANK_DEPTH-1:0][NIBBLE_W-1:0]    disp_next;
  logic                                   commit_pend;
  logic                                   scanning;
  logic                                   tc;
  logic                                   en_next;
  logic                                   last_sel;
  logic                                   boundary;
  logic                                   copy;
  logic                                   wr_fire;
  logic                                   cm_fire;
  logic [SEL_W-1:0]                       sel_next;

  assign scanning = (state == S_SCAN) && run;

  scan_prescaler #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .clear   (!scanning),
    .tc      (tc),
    .en_next (en_next)
  );

  assign last_sel = (sel == SEL_W'(NUM_DIGITS - 1));
  assign boundary = scanning && tc && last_sel;
  // In IDLE there is no frame to tear, so a pending commit lands immediately.
  assign copy     = commit_pend && (boundary || (state == S_IDLE));
  assign wr_fire  = host.wr_valid && !commit_pend && (int'(host.wr_addr) < NUM_DIGITS);
  assign cm_fire  = host.commit && !commit_pend;

  assign host.wr_ready = !commit_pend;

  always_comb begin
    sel_next  = '0;
    disp_next = copy ? shadow : disp;
    if (scanning) begin
      if (tc) sel_next = last_sel ? '0 : sel + SEL_W'(1);
      else    sel_next = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      sel         <= '0;
      sel_en      <= 1'b0;
      digit_val   <= '0;
      frame_tick  <= 1'b0;
      shadow      <= '0;
      disp        <= '0;
      commit_pend <= 1'b0;
    end else begin
      state      <= run ? S_SCAN : S_IDLE;
      sel        <= sel_next;
      sel_en     <= run && en_next;
      frame_tick <= boundary;
      // Read through disp_next so the frame_tick slot already shows committed data.
      digit_val  <= disp_next[sel_next];
      disp       <= disp_next;
      if (wr_fire) shadow[host.wr_addr] <= host.wr_data;
      if (copy)         commit_pend <= 1'b0;
      else if (cm_fire) commit_pend <= 1'b1;
    end
  end
endmodule
